// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : uart_tx_arbiter_if                                         |
// | Purpose  : Bundles the producer request/data signals and the uArtTx   |
// |            drive signals of uart_tx_arbiter.                          |
// | Signals  : baudSel    requested baud code (producer side)             |
// |            req        per-requester request level                     |
// |            reqData    byte i at bits [8i+7:8i]                        |
// |            grant      one-hot "byte taken" pulse                      |
// |            grantId    index of the last granted requester             |
// |            txData     byte to uArtTx dataInput                        |
// |            txStart    one-cycle start pulse to uArtTx                 |
// |            txBaudRate baud code to uArtTx baudRate                    |
// |            busy       frame in progress                               |
// | Modports : master = producers / environment, slave = arbiter          |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [1:0]           baudSel;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grantId;
  logic [7:0]           txData;
  logic                 txStart;
  logic [1:0]           txBaudRate;
  logic                 busy;

  modport master (
    output baudSel, req, reqData,
    input  grant, grantId, txData, txStart, txBaudRate, busy
  );

  modport slave (
    input  baudSel, req, reqData,
    output grant, grantId, txData, txStart, txBaudRate, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : uart_tx_arbiter                                            |
// | Purpose  : Round-robin arbiter/sequencer sharing one uArtTx between   |
// |            NUM_REQ byte producers. One requester is granted per       |
// |            frame; the frame is timed locally from the latched baud    |
// |            code because the transmitter has no busy output.           |
// | Ports    : clkTx  the only clock, rising edge                         |
// |            reset  synchronous, active-high                            |
// |            bus    uart_tx_arbiter_if.slave (req/data in, tx drive out)|
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int CPB_SLOWEST   = 41667,
  parameter int CPB_KINDASLOW = 20833,
  parameter int CPB_SLOW      = 10417,
  parameter int CPB_NORMAL    = 5208,
  parameter int GUARD_CLKS    = 2
) (
  input  wire logic          clkTx,
  input  wire logic          reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Last counter value of a frame (FRAME-1) per baud code, folded at
  // elaboration so no multiplier is built.
  localparam logic [19:0] c_LAST_B0 = 20'(10*CPB_SLOWEST   + GUARD_CLKS - 1);
  localparam logic [19:0] c_LAST_B1 = 20'(10*CPB_KINDASLOW + GUARD_CLKS - 1);
  localparam logic [19:0] c_LAST_B2 = 20'(10*CPB_SLOW      + GUARD_CLKS - 1);
  localparam logic [19:0] c_LAST_B3 = 20'(10*CPB_NORMAL    + GUARD_CLKS - 1);

  localparam logic [ID_W:0]   c_NUM  = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_LAST = ID_W'(NUM_REQ-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;

  logic [NUM_REQ-1:0]   r_grant,    w_grantNext;
  logic [ID_W-1:0]      r_grantId,  w_grantIdNext;
  logic [7:0]           r_txData,   w_txDataNext;
  logic                 r_txStart,  w_txStartNext;
  logic [1:0]           r_txBaud,   w_txBaudNext;
  logic                 r_busy,     w_busyNext;
  logic [19:0]          r_cnt,      w_cntNext;
  // Index holding the highest priority in the next IDLE decision.
  logic [ID_W-1:0]      r_ptr,      w_ptrNext;

  // Arbitration results
  logic [NUM_REQ-1:0]   w_reqRot;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;
  logic [ID_W-1:0]      w_winner;
  logic [NUM_REQ-1:0]   w_winnerOh;
  logic                 w_anyReq;
  logic [7:0]           w_winData;
  logic [19:0]          w_frameLast;

  // ---------------------------------------------------------------------
  // Round-robin search. The request vector is rotated so that bit 0 is the
  // pointer position; the lowest set bit of the rotated vector is then the
  // distance from the pointer to the winner.
  // ---------------------------------------------------------------------
  always_comb begin
    w_reqRot = NUM_REQ'({bus.req, bus.req} >> r_ptr);
    w_anyReq = |bus.req;
    w_off    = '0;
    // Descending scan so the lowest set bit is the one left in w_off.
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (w_reqRot[k]) begin
        w_off = ID_W'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= c_NUM) begin
      w_sum = w_sum - c_NUM;
    end
    w_winner   = w_sum[ID_W-1:0];
    w_winnerOh = NUM_REQ'(1) << w_winner;
    w_winData  = 8'(bus.reqData >> {w_winner, 3'b000});
  end

  // Frame end is chosen from the latched baud code only, so baudSel
  // changes mid-frame cannot stretch or shorten the frame in flight.
  always_comb begin
    w_frameLast = c_LAST_B0;
    case (r_txBaud)
      2'b00:   w_frameLast = c_LAST_B0;
      2'b01:   w_frameLast = c_LAST_B1;
      2'b10:   w_frameLast = c_LAST_B2;
      default: w_frameLast = c_LAST_B3;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are registered, so the IDLE
  // decision loads the grant/start values that are visible during ISSUE.
  // ---------------------------------------------------------------------
  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = '0;
    w_txStartNext = 1'b0;
    w_grantIdNext = r_grantId;
    w_txDataNext  = r_txData;
    w_txBaudNext  = r_txBaud;
    w_busyNext    = r_busy;
    w_cntNext     = r_cnt;
    w_ptrNext     = r_ptr;

    case (r_state)
      S_IDLE: begin
        w_txBaudNext = bus.baudSel;
        w_busyNext   = 1'b0;
        if (w_anyReq) begin
          w_grantNext   = w_winnerOh;
          w_txStartNext = 1'b1;
          w_txDataNext  = w_winData;
          w_grantIdNext = w_winner;
          w_busyNext    = 1'b1;
          w_ptrNext     = (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
          w_stateNext   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        w_cntNext   = '0;
        w_stateNext = S_SEND;
      end

      S_SEND: begin
        if (r_cnt == w_frameLast) begin
          w_cntNext   = '0;
          w_busyNext  = 1'b0;
          w_stateNext = S_IDLE;
        end else begin
          w_cntNext = r_cnt + 20'd1;
        end
      end

      default: begin
        w_busyNext  = 1'b0;
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clkTx) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_grantId <= '0;
      r_txData  <= '0;
      r_txStart <= 1'b0;
      r_txBaud  <= 2'b00;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_grantId <= w_grantIdNext;
      r_txData  <= w_txDataNext;
      r_txStart <= w_txStartNext;
      r_txBaud  <= w_txBaudNext;
      r_busy    <= w_busyNext;
      r_cnt     <= w_cntNext;
      r_ptr     <= w_ptrNext;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.grantId    = r_grantId;
  assign bus.txData     = r_txData;
  assign bus.txStart    = r_txStart;
  assign bus.txBaudRate = r_txBaud;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one uArtTx transmitter between NUM_REQ byte producers. It grants one requester per frame and drives the transmitter's data, start and baud-select inputs. The transmitter has no busy output, so the block times each frame itself from the baud setting. It sits between the producers (debug, status, trace) and the single uArtTx instance in the clkTx domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CPB_SLOWEST, 41667, clkTx cycles per bit for baud code 2'b00 (1200)
CPB_KINDASLOW, 20833, cycles per bit for code 2'b01 (2400)
CPB_SLOW, 10417, cycles per bit for code 2'b10 (4800)
CPB_NORMAL, 5208, cycles per bit for code 2'b11 (9600)
GUARD_CLKS, 2, extra idle cycles appended to each frame (must be >= 2)

Ports:
clkTx  in  1  the only clock; all logic on its rising edge
reset  in  1  synchronous, active-high; also drives the transmitter's reset
baudSel  in  2  requested baud code
req  in  NUM_REQ  per-requester request level
reqData  in  8*NUM_REQ  byte i is at bits [8i+7:8i]
grant  out  NUM_REQ  one-hot, one-cycle pulse meaning "byte taken"
grantId  out  clog2(NUM_REQ)  index of the last granted requester
txData  out  8  to uArtTx dataInput
txStart  out  1  to uArtTx start, one-cycle pulse
txBaudRate  out  2  to uArtTx baudRate
busy  out  1  high in ISSUE and SEND

Behaviour:
- All outputs are registered. Reset, sampled at a rising clkTx edge, forces:
  - state=IDLE; grant=0, grantId=0, txData=0, txStart=0, busy=0, txBaudRate=2'b00, counter=0
  - round-robin pointer cleared so that index 0 has the highest priority.
  - Reset overrides any in-progress frame, including mid-SEND. The next grant can occur no earlier than the cycle after reset deasserts.
- State IDLE:
  - txBaudRate <= baudSel every cycle.
  - If any req bit is set: the winner is the first set bit searching upward from (last grantId+1) mod NUM_REQ, wrapping. Go to ISSUE.
  - If no req bit is set: stay in IDLE.
- State ISSUE, exactly one cycle:
  - grant[winner]=1, txStart=1, txData=reqData[winner], grantId=winner, busy=1.
  - Then load counter=0 and go to SEND.
- State SEND:
  - grant=0, txStart=0, busy=1.
  - txData and txBaudRate are held constant.
  - Counter increments each cycle. When counter == FRAME-1, go to IDLE; busy drops on entry to IDLE.
- Frame length: FRAME = 10*CPB(txBaudRate) + GUARD_CLKS.
  - CPB is selected from the latched txBaudRate, never from live baudSel.
  - Counter width is 20 bits; the multiply is constant-folded via a 4-way mux of precomputed FRAME values.
- Timing:
  - Latency: req high at IDLE edge n gives grant/txStart high for cycle n+1.
  - Back-to-back issue interval is FRAME+2 cycles (IDLE 1 + ISSUE 1 + SEND FRAME).
- Requester protocol:
  - Requester holds req and data stable until its grant pulse.
  - It may keep req high to queue its next byte. It must change reqData in the cycle after grant.
  - Dropping req before grant is allowed and leaves no side effect.
- Boundary conditions:
  - baudSel changes during ISSUE/SEND are ignored until the next IDLE cycle.
  - A req arriving during SEND waits; there is no loss and no queue beyond req itself.
  - All requesters continuously asserting: grants rotate 0,1,2,3,0,...
  - Single requester: it is granted every FRAME+2 cycles.
  - A requester's req falling in the same cycle as the IDLE decision: the sampled value wins.

Test Plan:
Use CPB 4/8/16/32, GUARD 2 (FRAME 42/82/162/322) for all scenarios below.
- Reset then req=4'b0001, reqData[7:0]=8'hA5, baudSel=0 -> grant=0001 and txStart one cycle after the request edge; txData=A5; busy high 43 cycles; second txStart 44 cycles after the first.
- req=4'b1111 held, baudSel=3 -> grants 0,1,2,3,0 with txStart spacing 324 cycles; grantId follows; the serial line at uArtTx decodes each byte correctly.
- req=4'b1010 after granting index 1 -> next grant index 3, then 1.
- baudSel changed 0->3 mid-SEND -> current frame stays at 42 cycles with txBaudRate=0; the next frame uses code 3, spacing 324.
- Reset asserted 10 cycles into SEND -> next cycle all outputs at reset values and pointer back to 0; with req=4'b1001 the first grant is index 0.
- req pulsed for one cycle during SEND and dropped -> no grant is issued; the block returns to IDLE and stays idle.
